// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the CPU-side cache sequencing controller.
package cache_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_FILL      = 3'd3,
    ST_MEM_WRITE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  // Saturating increment; reset has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_o <= {WIDTH{1'b0}};
    end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
      count_o <= count_o + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_o <= count_o;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// One-request-at-a-time sequencer for a two-way cache: load refill on miss,
// write-through stores that update the cache only on a hit.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_busy_o,
  output logic                  cpu_resp_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  cache_fill_o,
  output logic [DATA_WIDTH-1:0] cache_fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  ctrl_state_t           state_r;
  ctrl_state_t           state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  we_r;
  logic                  hit_flag_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  hit_inc_s;
  logic                  miss_inc_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request, store-hit and refill-data latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_WIDTH{1'b0}};
      hit_flag_r <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && cpu_req_i) begin
      addr_r  <= cpu_addr_i;
      we_r    <= cpu_we_i;
      wdata_r <= cpu_wdata_i;
    end else if ((state_r == ST_LOOKUP) && we_r) begin
      hit_flag_r <= cache_hit_i;
    end else if ((state_r == ST_MEM_READ) && mem_ack_i) begin
      rdata_r <= mem_rdata_i;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:      state_nxt_s = cpu_req_i ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: begin
        if (we_r) begin
          state_nxt_s = ST_MEM_WRITE;
        end else if (cache_hit_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MEM_READ;
        end
      end
      ST_MEM_READ:  state_nxt_s = mem_ack_i ? ST_FILL : ST_MEM_READ;
      ST_FILL:      state_nxt_s = ST_IDLE;
      ST_MEM_WRITE: state_nxt_s = mem_ack_i ? ST_IDLE : ST_MEM_WRITE;
      default:      state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; load-hit data and the store ack response are same-cycle paths.
  always_comb begin
    cpu_busy_o        = (state_r != ST_IDLE);
    cpu_resp_o        = 1'b0;
    cpu_rdata_o       = {DATA_WIDTH{1'b0}};
    cache_addr_o      = addr_r;
    cache_fill_o      = 1'b0;
    cache_fill_data_o = {DATA_WIDTH{1'b0}};
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_addr_o        = addr_r;
    mem_wdata_o       = {DATA_WIDTH{1'b0}};
    hit_inc_s         = 1'b0;
    miss_inc_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cpu_busy_o = 1'b0;
      end
      ST_LOOKUP: begin
        hit_inc_s  = cache_hit_i;
        miss_inc_s = ~cache_hit_i;
        if (!we_r && cache_hit_i) begin
          cpu_resp_o  = 1'b1;
          cpu_rdata_o = cache_rdata_i;
        end else begin
          cpu_resp_o  = 1'b0;
        end
      end
      ST_MEM_READ: begin
        mem_req_o = 1'b1;
      end
      ST_FILL: begin
        cache_fill_o      = 1'b1;
        cache_fill_data_o = rdata_r;
        cpu_resp_o        = 1'b1;
        cpu_rdata_o       = rdata_r;
      end
      ST_MEM_WRITE: begin
        mem_req_o         = 1'b1;
        mem_we_o          = 1'b1;
        mem_wdata_o       = wdata_r;
        cache_fill_data_o = wdata_r;
        if (mem_ack_i) begin
          cpu_resp_o   = 1'b1;
          cache_fill_o = hit_flag_r;
        end else begin
          cpu_resp_o   = 1'b0;
        end
      end
      default: begin
        cpu_busy_o = 1'b0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit_inc_s),
    .count_o (hit_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (miss_inc_s),
    .count_o (miss_count_o)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed, table-driven bench for cache_controller with 3-bit counters so
// saturation is reachable in a handful of requests.
module tb_cache_controller;

  localparam logic F = 1'b0;
  localparam logic T = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic        cpu_busy_o, cpu_resp_o;
  logic [31:0] cpu_rdata_o, cache_addr_o;
  logic        cache_hit_i;
  logic [31:0] cache_rdata_i;
  logic        cache_fill_o;
  logic [31:0] cache_fill_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  hit_count_o, miss_count_o;

  int errors = 0;
  int checks = 0;

  cache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_busy_o(cpu_busy_o), .cpu_resp_o(cpu_resp_o),
    .cpu_rdata_o(cpu_rdata_o), .cache_addr_o(cache_addr_o), .cache_hit_i(cache_hit_i),
    .cache_rdata_i(cache_rdata_i), .cache_fill_o(cache_fill_o),
    .cache_fill_data_o(cache_fill_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        hit;
    logic [31:0] crd;
    logic        ack;
    logic [31:0] mrd;
    logic        busy, resp;
    logic [31:0] rdata;
    logic        fill;
    logic [31:0] fdata;
    logic        mreq, mwe;
    logic [31:0] mwd, eaddr;
    logic [2:0]  hc, mc;
  } vec_t;

  function automatic vec_t mk(
    input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
    input logic hit, input logic [31:0] crd, input logic ack, input logic [31:0] mrd,
    input logic busy, input logic resp, input logic [31:0] rdata, input logic fill,
    input logic [31:0] fdata, input logic mreq, input logic mwe, input logic [31:0] mwd,
    input logic [31:0] eaddr, input logic [2:0] hc, input logic [2:0] mc);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.hit = hit; v.crd = crd;
    v.ack = ack; v.mrd = mrd; v.busy = busy; v.resp = resp; v.rdata = rdata; v.fill = fill;
    v.fdata = fdata; v.mreq = mreq; v.mwe = mwe; v.mwd = mwd; v.eaddr = eaddr;
    v.hc = hc; v.mc = mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_i = F; cpu_we_i = F; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
    cache_hit_i = F; cache_rdata_i = 32'h0; mem_ack_i = F; mem_rdata_i = 32'h0;
  endtask

  vec_t tbl[18];

  initial begin
    // Cycle-by-cycle: load hit, load miss with 3-cycle memory, store hit, store miss
    // with same-cycle ack, then a stray ack while idle.
    tbl[0]  = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd0,3'd0);
    tbl[1]  = mk(T,F,32'h40,32'h0,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd0,3'd0);
    tbl[2]  = mk(F,F,32'h0,32'h0,T,32'hDEAD_BEEF,F,32'h0, T,T,32'hDEAD_BEEF,F,32'h0,F,F,32'h0,32'h40,3'd0,3'd0);
    tbl[3]  = mk(T,F,32'h80,32'h0,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd1,3'd0);
    tbl[4]  = mk(F,F,32'h0,32'h0,F,32'h55,F,32'h0, T,F,32'h0,F,32'h0,F,F,32'h0,32'h80,3'd1,3'd0);
    tbl[5]  = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, T,F,32'h0,F,32'h0,T,F,32'h0,32'h80,3'd1,3'd1);
    tbl[6]  = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, T,F,32'h0,F,32'h0,T,F,32'h0,32'h80,3'd1,3'd1);
    tbl[7]  = mk(F,F,32'h0,32'h0,F,32'h0,T,32'h1234_5678, T,F,32'h0,F,32'h0,T,F,32'h0,32'h80,3'd1,3'd1);
    tbl[8]  = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, T,T,32'h1234_5678,T,32'h1234_5678,F,F,32'h0,32'h80,3'd1,3'd1);
    tbl[9]  = mk(T,T,32'h100,32'hCAFE_F00D,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd1,3'd1);
    tbl[10] = mk(T,F,32'h300,32'h1111_1111,T,32'h0,F,32'h0, T,F,32'h0,F,32'h0,F,F,32'h0,32'h100,3'd1,3'd1);
    tbl[11] = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, T,F,32'h0,F,32'h0,T,T,32'hCAFE_F00D,32'h100,3'd2,3'd1);
    tbl[12] = mk(F,F,32'h0,32'h0,F,32'h0,T,32'h0, T,T,32'h0,T,32'hCAFE_F00D,T,T,32'hCAFE_F00D,32'h100,3'd2,3'd1);
    tbl[13] = mk(T,T,32'h100,32'hCAFE_F00D,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd2,3'd1);
    tbl[14] = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, T,F,32'h0,F,32'h0,F,F,32'h0,32'h100,3'd2,3'd1);
    tbl[15] = mk(F,F,32'h0,32'h0,T,32'h0,T,32'h0, T,T,32'h0,F,32'h0,T,T,32'hCAFE_F00D,32'h100,3'd2,3'd2);
    tbl[16] = mk(F,F,32'h0,32'h0,F,32'h0,T,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd2,3'd2);
    tbl[17] = mk(F,F,32'h0,32'h0,F,32'h0,F,32'h0, F,F,32'h0,F,32'h0,F,F,32'h0,32'h0,3'd2,3'd2);

    idle_inputs();
    rst = T;
    repeat (2) @(posedge clk);
    #1;
    rst = F;
    #1;
    check("reset_rdata", cpu_rdata_o, 32'h0);
    check("reset_cache_addr", cache_addr_o, 32'h0);
    check("reset_mem_addr", mem_addr_o, 32'h0);
    check("reset_fill_data", cache_fill_data_o, 32'h0);
    check("reset_mem_wdata", mem_wdata_o, 32'h0);

    for (int i = 0; i < 18; i++) begin
      cpu_req_i = tbl[i].req; cpu_we_i = tbl[i].we; cpu_addr_i = tbl[i].addr;
      cpu_wdata_i = tbl[i].wdata; cache_hit_i = tbl[i].hit; cache_rdata_i = tbl[i].crd;
      mem_ack_i = tbl[i].ack; mem_rdata_i = tbl[i].mrd;
      #1;
      check($sformatf("v%0d_busy", i), {31'h0, cpu_busy_o}, {31'h0, tbl[i].busy});
      check($sformatf("v%0d_resp", i), {31'h0, cpu_resp_o}, {31'h0, tbl[i].resp});
      check($sformatf("v%0d_fill", i), {31'h0, cache_fill_o}, {31'h0, tbl[i].fill});
      check($sformatf("v%0d_mem_req", i), {31'h0, mem_req_o}, {31'h0, tbl[i].mreq});
      check($sformatf("v%0d_mem_we", i), {31'h0, mem_we_o}, {31'h0, tbl[i].mwe});
      check($sformatf("v%0d_hit_cnt", i), {29'h0, hit_count_o}, {29'h0, tbl[i].hc});
      check($sformatf("v%0d_miss_cnt", i), {29'h0, miss_count_o}, {29'h0, tbl[i].mc});
      if (tbl[i].resp && !tbl[i].mwe) check($sformatf("v%0d_rdata", i), cpu_rdata_o, tbl[i].rdata);
      if (tbl[i].fill) check($sformatf("v%0d_fill_data", i), cache_fill_data_o, tbl[i].fdata);
      if (tbl[i].mwe) check($sformatf("v%0d_mem_wdata", i), mem_wdata_o, tbl[i].mwd);
      if (tbl[i].busy) begin
        check($sformatf("v%0d_cache_addr", i), cache_addr_o, tbl[i].eaddr);
        check($sformatf("v%0d_mem_addr", i), mem_addr_o, tbl[i].eaddr);
      end
      tick();
    end

    // Reset while a refill is outstanding.
    idle_inputs();
    cpu_req_i = T; cpu_addr_i = 32'h200;
    tick();
    cpu_req_i = F;
    tick();
    #1;
    check("rstmid_mem_req_before", {31'h0, mem_req_o}, 32'h1);
    rst = T;
    tick();
    rst = F;
    #1;
    check("rstmid_busy", {31'h0, cpu_busy_o}, 32'h0);
    check("rstmid_mem_req", {31'h0, mem_req_o}, 32'h0);
    check("rstmid_resp", {31'h0, cpu_resp_o}, 32'h0);
    check("rstmid_hit_cnt", {29'h0, hit_count_o}, 32'h0);
    check("rstmid_miss_cnt", {29'h0, miss_count_o}, 32'h0);
    cpu_req_i = T; cpu_addr_i = 32'h200;
    tick();
    cpu_req_i = F; cache_hit_i = T; cache_rdata_i = 32'hA5A5_0001;
    #1;
    check("post_rst_resp", {31'h0, cpu_resp_o}, 32'h1);
    check("post_rst_rdata", cpu_rdata_o, 32'hA5A5_0001);
    check("post_rst_addr", cache_addr_o, 32'h200);
    tick();
    cache_hit_i = F;
    #1;
    check("post_rst_resp_gap", {31'h0, cpu_resp_o}, 32'h0);
    check("post_rst_hit_cnt", {29'h0, hit_count_o}, 32'h1);

    // Hit counter climbs to all-ones (7) and stays there.
    for (int k = 0; k < 8; k++) begin
      cpu_req_i = T; cpu_addr_i = 32'h40;
      tick();
      cpu_req_i = F; cache_hit_i = T; cache_rdata_i = 32'h0000_0100 + k;
      #1;
      check($sformatf("sat%0d_resp", k), {31'h0, cpu_resp_o}, 32'h1);
      tick();
      cache_hit_i = F;
      #1;
      check($sformatf("sat%0d_hit_cnt", k), {29'h0, hit_count_o}, (k + 2 > 7) ? 32'd7 : 32'(k + 2));
    end
    check("sat_miss_cnt", {29'h0, miss_count_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for the two-way associative cache on the CPU memory path. It accepts one CPU load/store at a time and drives the cache array's lookup and fill signals. On a load miss it fetches the word from main memory and refills the cache. Stores are write-through to memory and update the cache only on a hit. Saturating hit/miss counters support performance measurement.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- CNT_WIDTH, 32, width of each statistics counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_i  in  1  CPU request valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_WIDTH  request address
- cpu_wdata_i  in  DATA_WIDTH  store data
- cpu_busy_o  out  1  controller not in IDLE; request accepted only when 0
- cpu_resp_o  out  1  one-cycle completion pulse
- cpu_rdata_o  out  DATA_WIDTH  load data, valid when cpu_resp_o=1 for a load
- cache_addr_o  out  ADDR_WIDTH  address presented to cache array
- cache_hit_i  in  1  cache hit for cache_addr_o (combinational, same cycle)
- cache_rdata_i  in  DATA_WIDTH  cache data for cache_addr_o (same cycle)
- cache_fill_o  out  1  write cache_fill_data_o at cache_addr_o (cache picks LRU way on miss, hit way on hit)
- cache_fill_data_o  out  DATA_WIDTH  fill/update data
- mem_req_o  out  1  memory request, held until acked
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_ack_i  in  1  memory done; mem_rdata_i valid this cycle for reads
- mem_rdata_i  in  DATA_WIDTH  memory read data
- hit_count_o  out  CNT_WIDTH  lookups that hit
- miss_count_o  out  CNT_WIDTH  lookups that missed

## Operation
- States: IDLE, LOOKUP, MEM_READ, FILL, MEM_WRITE.
- IDLE: if cpu_req_i, latch addr, we and wdata; go to LOOKUP.
- LOOKUP: cache_addr_o = latched addr. Increment hit or miss counter by cache_hit_i (loads and stores).
  - Load hit: cpu_resp_o=1, cpu_rdata_o=cache_rdata_i; go to IDLE.
  - Load miss: go to MEM_READ.
  - Store: latch hit flag; go to MEM_WRITE.
- MEM_READ: mem_req_o=1, mem_we_o=0, mem_addr_o=latched addr. On mem_ack_i, latch mem_rdata_i and go to FILL.
- FILL: cache_fill_o=1 with the latched read data, cpu_resp_o=1, cpu_rdata_o = same data; go to IDLE.
- MEM_WRITE: mem_req_o=1, mem_we_o=1, wdata = latched store data. On mem_ack_i:
  - cpu_resp_o=1.
  - cache_fill_o=1 with store data only if the hit flag is set. No write-allocate.
  - Go to IDLE.
- cache_addr_o and mem_addr_o always carry the latched address outside IDLE.
- Counters saturate at all-ones; no wrap.
- Reset values: state IDLE; all 1-bit outputs 0; data, address and counter outputs 0.

## Timing
- Accept in cycle N (IDLE, cpu_req_i=1) means LOOKUP in N+1.
- Load hit: cpu_resp_o in N+1, so latency 1.
- Load miss with mem_ack_i in cycle K: FILL and cpu_resp_o in K+1.
- Store with mem_ack_i in cycle K: cpu_resp_o and optional fill in K (Mealy on ack).
- Earliest next accept is the cycle after cpu_resp_o. A request asserted while busy is ignored; the CPU must hold it.
- mem_ack_i outside MEM_READ/MEM_WRITE is ignored.
- Memory responding in the same cycle as the request (ack on first MEM_* cycle) is legal.
- cpu_resp_o is never asserted in two consecutive cycles.
- rst mid-operation: IDLE next edge, mem_req_o drops, counters clear, no cpu_resp_o. Memory must tolerate the abandoned request.
- rst has priority over every transition and counter increment.

## Structure
- Package cache_ctrl_pkg: state enum type (ctrl_state_t) and default width constants.
- Sub-module sat_counter (parameter WIDTH; ports clk, rst, inc_i, count_o), instanced twice for the hit and miss counters.
- FSM, request latches and output decode live in cache_controller.

## Test plan
- Reset, then idle: all outputs 0, cpu_busy_o=0, counters 0.
- Load 0x0000_0040, cache_hit_i=1, rdata 0xDEAD_BEEF: cpu_resp_o one cycle after accept with 0xDEAD_BEEF; hit_count_o=1; no mem_req_o.
- Load 0x0000_0080 miss, memory acks after 3 cycles with 0x1234_5678: mem_req_o held 3 cycles; FILL cycle has cache_fill_o=1 and cpu_resp_o=1 with 0x1234_5678; miss_count_o=1.
- Store 0xCAFE_F00D to 0x100:
  - hit: mem write plus cache_fill_o on the ack cycle.
  - miss: mem write only, cache_fill_o stays 0.
- rst asserted during MEM_READ: next cycle state IDLE, mem_req_o=0, no cpu_resp_o, counters 0. A following load proceeds normally.
- Preload the hit counter to all-ones minus 1, then do 3 hits: the counter holds all-ones.
